pll_hdmi_cfg: RTL

//  Management-side controller that drives the HDMI PLL reconfig_to_pll bus and monitors reconfig_from_pll.

---
 rtl/pll_cfg_pkg.sv | 28 ++
 rtl/pll_cfg_fifo.sv | 32 +++
 rtl/pll_hdmi_cfg.sv | 135 +++++++++++++
 3 files changed

// File: rtl/pll_cfg_pkg.sv
// pll_cfg_pkg: register map, PLL bus field offsets, FSM encoding and replay order
package pll_cfg_pkg;
    localparam logic [5:0] A_MODE = 6'd0, A_STATUS = 6'd1, A_START = 6'd2, A_N = 6'd3, A_M = 6'd4,
                           A_C = 6'd5, A_K = 6'd7, A_BW = 6'd8, A_CP = 6'd9;
    localparam int TO_DATA_LSB = 0, TO_ADDR_LSB = 32, TO_WR_BIT = 38;
    localparam int FROM_LOCKED_BIT = 0, FROM_BUSY_BIT = 1;
    localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_SEND = 3'd2, S_ACK = 3'd3,
                           S_LOCKWAIT = 3'd4, S_DONE = 3'd5;
    // item codes are numbered in replay order, so the lowest pending code goes next
    localparam logic [2:0] IT_N = 3'd0, IT_M = 3'd1, IT_C = 3'd2, IT_K = 3'd3, IT_BW = 3'd4,
                           IT_CP = 3'd5, IT_NONE = 3'd7, NO_IDX = 3'd7;
    localparam logic [5:0] ITEM_ADDR [6] = '{A_N, A_M, A_C, A_K, A_BW, A_CP};

    function automatic logic [2:0] next_item(input logic [5:0] pend);
        next_item = IT_NONE;
        for (int i = 5; i >= 0; i--)
            if (pend[i]) next_item = 3'(i);
    endfunction

    function automatic logic [2:0] item_idx(input logic [2:0] it);
        return it < IT_C ? it : it - 3'd1;
    endfunction

    function automatic logic [2:0] reg_idx(input logic [5:0] a);
        return a == A_N ? 3'd0 : a == A_M ? 3'd1 : a == A_K ? 3'd2 :
               a == A_BW ? 3'd3 : a == A_CP ? 3'd4 : NO_IDX;
    endfunction
endpackage

// File: rtl/pll_cfg_fifo.sv
// pll_cfg_fifo: synchronous FIFO queueing C-counter writes
module pll_cfg_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    assign empty = wp == rp;
    assign full = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
    assign dout = mem[rp[AW-1:0]];
    always_ff @(posedge clk)
        if (push && !full) mem[wp[AW-1:0]] <= din;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) wp <= wp + 1'b1;
            if (pop && !empty) rp <= rp + 1'b1;
        end
    end
endmodule

// File: rtl/pll_hdmi_cfg.sv
// pll_hdmi_cfg: replays dirty PLL shadow registers over reconfig_to_pll and waits for lock
module pll_hdmi_cfg
    import pll_cfg_pkg::*;
#(
    parameter logic [19:0] LOCK_TIMEOUT = 20'd1000000,
    parameter int CFIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  mgmt_address,
    input  logic        mgmt_read,
    input  logic        mgmt_write,
    input  logic [31:0] mgmt_writedata,
    output logic [31:0] mgmt_readdata,
    output logic        mgmt_waitrequest,
    output logic [63:0] reconfig_to_pll,
    input  logic [63:0] reconfig_from_pll,
    output logic        cfg_done,
    output logic        cfg_err
);
    logic [1:0] sync1, sync2;
    logic [2:0] state, item, w_idx, r_idx, nxt;
    logic [31:0] shadow [5];
    logic [4:0] dirty;
    logic mode, ack_min, to_wr, stall, wr_acc, rd_acc, fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [5:0] to_addr;
    logic [31:0] to_data, rd_mux, fifo_dout;
    logic [19:0] cnt;
    logic busy_s, locked_s, waiting, unused_from;

    assign unused_from = ^reconfig_from_pll[63:2];
    assign busy_s = sync2[FROM_BUSY_BIT];
    assign locked_s = sync2[FROM_LOCKED_BIT];
    assign waiting = state == S_ACK || state == S_LOCKWAIT;
    // STATUS reads bypass the stall so the host can poll progress
    assign stall = (state != S_IDLE && !(mgmt_read && !mgmt_write && mgmt_address == A_STATUS))
                   || (mgmt_write && mgmt_address == A_C && fifo_full);
    assign mgmt_waitrequest = !rst_n || stall;
    assign wr_acc = mgmt_write && !mgmt_waitrequest;
    assign rd_acc = mgmt_read && !mgmt_write && !mgmt_waitrequest;
    assign fifo_push = wr_acc && mgmt_address == A_C;
    assign fifo_pop = state == S_SEND && item == IT_C;
    assign w_idx = reg_idx(mgmt_address);
    assign r_idx = reg_idx(mgmt_address);
    assign nxt = next_item({dirty[4:2], !fifo_empty, dirty[1:0]});
    assign cfg_done = state == S_DONE;

    always_comb begin
        reconfig_to_pll = '0;
        reconfig_to_pll[TO_WR_BIT] = to_wr;
        reconfig_to_pll[TO_ADDR_LSB +: 6] = to_addr;
        reconfig_to_pll[TO_DATA_LSB +: 32] = to_data;
    end

    always_comb begin
        rd_mux = '0;
        if (mgmt_address == A_MODE) rd_mux = {31'b0, mode};
        else if (mgmt_address == A_STATUS) rd_mux = {29'b0, cfg_err, state != S_IDLE, locked_s};
        else if (r_idx != NO_IDX) rd_mux = shadow[r_idx];
    end

    pll_cfg_fifo #(.DEPTH(CFIFO_DEPTH), .W(32)) u_fifo (
        .clk(clk), .rst_n(rst_n), .push(fifo_push), .pop(fifo_pop),
        .din(mgmt_writedata), .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= reconfig_from_pll[1:0];
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            item <= '0;
            dirty <= '0;
            mode <= 1'b0;
            cfg_err <= 1'b0;
            to_wr <= 1'b0;
            to_addr <= '0;
            to_data <= '0;
            cnt <= '0;
            ack_min <= 1'b0;
            mgmt_readdata <= '0;
            for (int i = 0; i < 5; i++) shadow[i] <= '0;
        end else begin
            to_wr <= 1'b0;
            if (rd_acc) mgmt_readdata <= rd_mux;
            if (wr_acc && mgmt_address == A_MODE) mode <= mgmt_writedata[0];
            if (wr_acc && w_idx != NO_IDX) begin
                shadow[w_idx] <= mgmt_writedata;
                dirty[w_idx] <= 1'b1;
            end
            if (waiting) cnt <= cnt + 20'd1;
            case (state)
                S_IDLE:
                    if (wr_acc && mgmt_address == A_START) begin
                        state <= S_LOAD;
                        cfg_err <= 1'b0;
                        cnt <= '0;
                    end
                S_LOAD:
                    if (nxt == IT_NONE) state <= S_LOCKWAIT;
                    else begin
                        state <= S_SEND;
                        item <= nxt;
                        to_wr <= 1'b1;
                        to_addr <= ITEM_ADDR[nxt];
                        to_data <= nxt == IT_C ? fifo_dout : shadow[item_idx(nxt)];
                    end
                S_SEND: begin
                    state <= S_ACK;
                    cnt <= '0;
                    ack_min <= 1'b0;
                    if (item != IT_C) dirty[item_idx(item)] <= 1'b0;
                end
                S_ACK: begin
                    ack_min <= 1'b1;
                    if (ack_min && !busy_s) state <= S_LOAD;
                end
                S_LOCKWAIT: if (!busy_s && locked_s) state <= S_DONE;
                default: state <= S_IDLE;
            endcase
            if (waiting && cnt == LOCK_TIMEOUT - 20'd1) begin
                state <= S_IDLE;
                cfg_err <= 1'b1;
            end
        end
    end
endmodule
